// File: rtl/if_fetch_queue_if.sv
// Instruction-memory request/response channel between the fetch queue and the memory.
// Requests are valid/ready; responses are valid-only and return in request order.
interface if_fetch_queue_if #(
    parameter int PC_W  = 32,
    parameter int INS_W = 32
);
    logic             req_valid;
    logic [PC_W-1:0]  req_addr;
    logic             req_ready;
    logic             resp_valid;
    logic [INS_W-1:0] resp_data;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  resp_valid,
        input  resp_data
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output resp_valid,
        output resp_data
    );
endinterface

// File: rtl/if_fetch_queue.sv
// Fetch front end: owns the fetch PC, issues credit-limited in-order requests and
// buffers returned instructions for the IF/ID register, flushing on redirects.
module if_fetch_queue #(
    parameter int              PC_W     = 32,
    parameter int              INS_W    = 32,
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    if_fetch_queue_if.master  imem,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    input  logic              stall,
    output logic              id_valid,
    output logic [PC_W-1:0]   id_pc,
    output logic [PC_W-1:0]   id_pc_plus4,
    output logic [INS_W-1:0]  id_instr
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0]    FULL = CW'(DEPTH);
    localparam logic [INS_W-1:0] NOP  = INS_W'(32'h0000_0013);

    typedef enum logic {RUN, DRAIN} state_t;

    state_t           state_reg;
    logic [PC_W-1:0]  fetch_pc_reg;
    logic [PC_W-1:0]  resp_pc_reg;
    logic [CW-1:0]    count_reg;
    logic [CW-1:0]    outstanding_reg;
    logic [CW-1:0]    stale_reg;
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [PC_W-1:0]  hold_pc_reg;
    logic [PC_W-1:0]  hold_pc4_reg;

    logic [PC_W-1:0]  slot_pc    [DEPTH];
    logic [INS_W-1:0] slot_instr [DEPTH];

    logic [CW:0]      credit_used;
    logic             accept;
    logic             push;
    logic             pop;
    logic [CW-1:0]    outstanding_next;
    logic [PC_W-1:0]  redirect_target;
    logic [PC_W-1:0]  head_pc;

    // Credits cover both in-flight requests and buffered entries, so a response
    // always finds a free slot.
    assign credit_used     = {1'b0, outstanding_reg} + {1'b0, count_reg};
    assign imem.req_valid  = !reset && (state_reg == RUN) && !redirect_valid
                             && (credit_used < {1'b0, FULL});
    assign imem.req_addr   = fetch_pc_reg;

    assign accept           = imem.req_valid && imem.req_ready;
    assign push             = imem.resp_valid && (state_reg == RUN) && !redirect_valid;
    assign pop              = id_valid && !stall && !redirect_valid;
    assign outstanding_next = outstanding_reg + CW'(accept) - CW'(imem.resp_valid);
    assign redirect_target  = redirect_pc & ~PC_W'(3);

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        logic [PC_W-1:0]  pc_reg;
        logic [INS_W-1:0] instr_reg;

        always_ff @(posedge clk) begin
            if (!reset && push && (wr_ptr_reg == AW'(gi))) begin
                pc_reg    <= resp_pc_reg;
                instr_reg <= imem.resp_data;
            end
        end

        assign slot_pc[gi]    = pc_reg;
        assign slot_instr[gi] = instr_reg;
    end

    assign head_pc     = slot_pc[rd_ptr_reg];
    assign id_valid    = (count_reg != '0);
    assign id_pc       = id_valid ? head_pc : hold_pc_reg;
    assign id_pc_plus4 = id_valid ? head_pc + PC_W'(4) : hold_pc4_reg;
    assign id_instr    = id_valid ? slot_instr[rd_ptr_reg] : NOP;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= RUN;
            fetch_pc_reg    <= RESET_PC;
            resp_pc_reg     <= RESET_PC;
            count_reg       <= '0;
            outstanding_reg <= '0;
            stale_reg       <= '0;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            hold_pc_reg     <= '0;
            hold_pc4_reg    <= '0;
        end else begin
            outstanding_reg <= outstanding_next;
            if (id_valid) begin
                hold_pc_reg  <= head_pc;
                hold_pc4_reg <= head_pc + PC_W'(4);
            end
            if (redirect_valid) begin
                // Everything issued before the redirect is still owed by memory
                // and must be swallowed before the new stream starts.
                count_reg    <= '0;
                rd_ptr_reg   <= wr_ptr_reg;
                fetch_pc_reg <= redirect_target;
                resp_pc_reg  <= redirect_target;
                stale_reg    <= outstanding_next;
                state_reg    <= (outstanding_next != '0) ? DRAIN : RUN;
            end else begin
                if (accept) begin
                    fetch_pc_reg <= fetch_pc_reg + PC_W'(4);
                end
                if (push) begin
                    wr_ptr_reg  <= wr_ptr_reg + AW'(1);
                    resp_pc_reg <= resp_pc_reg + PC_W'(4);
                end
                if (pop) begin
                    rd_ptr_reg <= rd_ptr_reg + AW'(1);
                end
                count_reg <= count_reg + CW'(push) - CW'(pop);
                if ((state_reg == DRAIN) && imem.resp_valid) begin
                    stale_reg <= stale_reg - CW'(1);
                    if (stale_reg == CW'(1)) begin
                        state_reg <= RUN;
                    end
                end
            end
        end
    end

    a_no_push_when_full: assert property (@(posedge clk) disable iff (reset)
        !(push && (count_reg == FULL)));

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: in-order memory model with programmable latency and a
// scoreboard of expected PCs that is flushed on every redirect or reset.
module tb_if_fetch_queue;
    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        stall = 1'b0;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic [31:0] id_instr;

    if_fetch_queue_if #(.PC_W(32), .INS_W(32)) imem ();

    if_fetch_queue #(
        .PC_W(32), .INS_W(32), .DEPTH(DEPTH), .RESET_PC(32'h0)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem           (imem),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4),
        .id_instr       (id_instr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    typedef struct {
        int          lat;
        int          pre;
        logic [31:0] target;
        logic [31:0] exp_addr;
        logic [31:0] exp_pc;
    } redir_vec_t;

    mreq_t       mem_q[$];
    logic [31:0] sb_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cycle = 0;
    int          lat = 1;
    int          n_pops = 0;
    bit          last_acc;
    bit          last_pop;
    logic [31:0] last_acc_addr = '0;
    logic [31:0] last_pop_pc = '0;
    logic [31:0] exp_fetch_pc = '0;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ {a[31:16], 16'h0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: sample at the falling edge, then update the memory model and
    // scoreboard just after the rising edge.
    task automatic tick();
        bit          acc;
        bit          rsp;
        bit          pop;
        bit          redir;
        bit          rst;
        logic [31:0] e;
        @(negedge clk);
        rst   = reset;
        acc   = !rst && (imem.req_valid === 1'b1) && imem.req_ready;
        rsp   = imem.resp_valid;
        redir = !rst && redirect_valid;
        pop   = !rst && (id_valid === 1'b1) && !stall && !redirect_valid;
        last_acc = acc;
        last_pop = pop;
        if (!rst) begin
            if (id_valid !== 1'b1) check("bubble_nop", id_instr, NOP);
            if (acc) begin
                check("req_addr", imem.req_addr, exp_fetch_pc);
                last_acc_addr = imem.req_addr;
            end
            if (pop) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_pop: got pc %h, expected no valid entry", id_pc);
                end else begin
                    e = sb_q.pop_front();
                    check("id_pc", id_pc, e);
                    check("id_pc_plus4", id_pc_plus4, e + 32'd4);
                    check("id_instr", id_instr, instr_of(e));
                end
                last_pop_pc = id_pc;
                n_pops++;
                $display("cycle %0d pop pc=%h pc4=%h instr=%h", cycle, id_pc, id_pc_plus4, id_instr);
            end
        end
        @(posedge clk);
        #1;
        cycle++;
        if (rst) begin
            mem_q.delete();
            sb_q.delete();
            exp_fetch_pc = 32'h0;
        end else begin
            if (rsp && mem_q.size() > 0) mem_q.delete(0);
            if (acc) begin
                mem_q.push_back('{addr: last_acc_addr, due: cycle + lat});
                sb_q.push_back(exp_fetch_pc);
                exp_fetch_pc += 32'd4;
            end
            if (redir) begin
                sb_q.delete();
                exp_fetch_pc = redirect_pc & ~32'h3;
            end
        end
        if (mem_q.size() > 0 && mem_q[0].due <= cycle + 1) begin
            imem.resp_valid = 1'b1;
            imem.resp_data  = instr_of(mem_q[0].addr);
        end else begin
            imem.resp_valid = 1'b0;
            imem.resp_data  = '0;
        end
    endtask

    task automatic expect_next_acc(input string name, input logic [31:0] exp);
        bit got = 0;
        for (int k = 0; k < 60 && !got; k++) begin
            tick();
            if (last_acc) got = 1;
        end
        if (got) check(name, last_acc_addr, exp);
        else begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: no request within bound, expected addr %h", name, exp);
        end
    endtask

    task automatic expect_next_pop(input string name, input logic [31:0] exp);
        bit got = 0;
        for (int k = 0; k < 60 && !got; k++) begin
            tick();
            if (last_pop) got = 1;
        end
        if (got) check(name, last_pop_pc, exp);
        else begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: no instruction within bound, expected pc %h", name, exp);
        end
    endtask

    task automatic do_redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        tick();
        redirect_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        redir_vec_t  vecs[4];
        logic [31:0] hold_pc;
        logic [31:0] hold_instr;

        vecs[0] = '{lat: 3, pre: 12, target: 32'h0000_0103, exp_addr: 32'h0000_0100, exp_pc: 32'h0000_0100};
        vecs[1] = '{lat: 1, pre: 6,  target: 32'hFFFF_FFF8, exp_addr: 32'hFFFF_FFF8, exp_pc: 32'hFFFF_FFF8};
        vecs[2] = '{lat: 2, pre: 5,  target: 32'h0000_2002, exp_addr: 32'h0000_2000, exp_pc: 32'h0000_2000};
        vecs[3] = '{lat: 4, pre: 9,  target: 32'h0000_0007, exp_addr: 32'h0000_0004, exp_pc: 32'h0000_0004};

        imem.req_ready  = 1'b0;
        imem.resp_valid = 1'b0;
        imem.resp_data  = '0;

        // Reset and first-fetch latency
        reset = 1'b1;
        repeat (3) tick();
        check("rst_req_valid", 32'(imem.req_valid), 32'd0);
        check("rst_id_valid", 32'(id_valid), 32'd0);
        check("rst_id_instr", id_instr, NOP);
        check("rst_id_pc", id_pc, 32'h0);
        check("rst_id_pc_plus4", id_pc_plus4, 32'h0);
        reset = 1'b0;
        imem.req_ready = 1'b1;
        lat = 1;
        tick();
        check("first_accept", 32'(last_acc), 32'd1);
        check("first_addr", last_acc_addr, 32'h0);
        check("idv_before_push", 32'(id_valid), 32'd0);
        tick();
        check("idv_rise", 32'(id_valid), 32'd1);
        check("first_id_pc", id_pc, 32'h0);
        check("first_id_pc_plus4", id_pc_plus4, 32'h4);
        n_pops = 0;
        repeat (20) tick();
        check("throughput_pops", n_pops, 32'd20);

        // Backpressure
        stall      = 1'b1;
        hold_pc    = id_pc;
        hold_instr = id_instr;
        repeat (10) tick();
        check("stall_id_valid", 32'(id_valid), 32'd1);
        check("stall_id_pc", id_pc, hold_pc);
        check("stall_id_instr", id_instr, hold_instr);
        check("stall_req_valid", 32'(imem.req_valid), 32'd0);
        check("stall_inflight", sb_q.size(), DEPTH);
        stall = 1'b0;
        repeat (20) tick();

        // Redirect vectors
        for (int i = 0; i < 4; i++) begin
            lat = vecs[i].lat;
            repeat (vecs[i].pre) tick();
            do_redirect(vecs[i].target);
            check("flush_id_valid", 32'(id_valid), 32'd0);
            check("drain_req_gate", 32'(imem.req_valid), 32'(mem_q.size() == 0));
            expect_next_acc("redir_addr", vecs[i].exp_addr);
            expect_next_pop("redir_id_pc", vecs[i].exp_pc);
            repeat (3 * DEPTH) tick();
        end

        // Address wrap and pointer wrap
        lat = 1;
        do_redirect(32'hFFFF_FFF8);
        expect_next_acc("wrap_addr0", 32'hFFFF_FFF8);
        expect_next_acc("wrap_addr1", 32'hFFFF_FFFC);
        expect_next_acc("wrap_addr2", 32'h0000_0000);
        n_pops = 0;
        repeat (3 * DEPTH + 4) tick();
        check("wrap_pops", 32'(n_pops >= 2 * DEPTH + 1), 32'd1);

        // Redirect colliding with a response and a pop
        for (int k = 0; k < 20 && !(imem.resp_valid && id_valid); k++) tick();
        check("sim_setup", 32'(imem.resp_valid && id_valid), 32'd1);
        do_redirect(32'h0000_0400);
        check("sim_no_pop", 32'(last_pop), 32'd0);
        check("sim_id_valid", 32'(id_valid), 32'd0);
        expect_next_pop("sim_first_pc", 32'h0000_0400);
        repeat (8) tick();

        // Reset while draining stale responses
        lat = 4;
        repeat (10) tick();
        do_redirect(32'h0000_0800);
        for (int k = 0; k < 20 && mem_q.size() > 2; k++) tick();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        check("mid_rst_id_valid", 32'(id_valid), 32'd0);
        check("mid_rst_id_pc", id_pc, 32'h0);
        expect_next_acc("mid_rst_addr", 32'h0);
        expect_next_pop("mid_rst_pc", 32'h0);
        repeat (10) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
